// File: rtl/controlador_displays_mux.sv
// Time-multiplexed driver for N common-anode 7-segment digits: hex decode, decimal points,
// leading-zero blanking, per-slot dead time and a per-frame snapshot of the displayed value.
module controlador_displays_mux #(
  parameter int N_DIGITOS   = 4,
  parameter int CLK_DIV     = 100000,
  parameter int BLANK_CYC   = 2,
  parameter bit ACTIVO_BAJO = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*N_DIGITOS-1:0] valor,
  input  logic [N_DIGITOS-1:0]   punto,
  input  logic                   blank_ceros,
  input  logic                   habilitar,
  output logic [N_DIGITOS-1:0]   anodo,
  output logic [6:0]             segmento,
  output logic                   dp,
  output logic [2:0]             digito_actual
);

  localparam int              PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   BLANK_P   = PW'(BLANK_CYC);
  localparam logic [2:0]      IDX_MAX   = 3'(N_DIGITOS - 1);

  localparam logic [N_DIGITOS-1:0] ANODO_OFF = ACTIVO_BAJO ? '1 : '0;
  localparam logic [6:0]           SEG_OFF   = ACTIVO_BAJO ? 7'h7F : 7'h00;
  localparam logic                 DP_OFF    = ACTIVO_BAJO ? 1'b1 : 1'b0;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  logic [PW-1:0]          presc_q, presc_d;
  logic [2:0]             idx_q, idx_d;
  logic [4*N_DIGITOS-1:0] snap_valor_q, snap_valor_d;
  logic [N_DIGITOS-1:0]   snap_punto_q, snap_punto_d;
  logic [N_DIGITOS-1:0]   anodo_q, anodo_d;
  logic [6:0]             segmento_q, segmento_d;
  logic                   dp_q, dp_d;
  logic [2:0]             digito_q, digito_d;

  logic                   captura;
  logic                   run_ceros;
  logic                   lit;
  logic [N_DIGITOS-1:0]   blank_vec;
  logic [N_DIGITOS-1:0]   anodo_act;
  logic [3:0]             nib_sel;
  logic                   punto_sel;
  logic                   blank_sel;
  logic [6:0]             seg_low;

  always_comb begin
    captura      = (presc_q == '0) && (idx_q == 3'd0);
    // The capture cycle already decodes the incoming value so the whole frame is consistent.
    snap_valor_d = captura ? valor : snap_valor_q;
    snap_punto_d = captura ? punto : snap_punto_q;

    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end

    run_ceros = 1'b1;
    blank_vec = '0;
    for (int k = N_DIGITOS - 1; k >= 0; k--) begin
      run_ceros    = run_ceros & (snap_valor_d[4*k +: 4] == 4'h0);
      blank_vec[k] = blank_ceros & run_ceros & (k != 0);
    end

    nib_sel   = 4'h0;
    punto_sel = 1'b0;
    blank_sel = 1'b0;
    anodo_act = '0;
    lit       = habilitar && (presc_q >= BLANK_P);
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (idx_q == 3'(k)) begin
        nib_sel      = snap_valor_d[4*k +: 4];
        punto_sel    = snap_punto_d[k];
        blank_sel    = blank_vec[k];
        anodo_act[k] = lit;
      end
    end

    seg_low    = blank_sel ? 7'h7F : seg_decode(nib_sel);
    anodo_d    = ACTIVO_BAJO ? ~anodo_act : anodo_act;
    segmento_d = ACTIVO_BAJO ? seg_low : ~seg_low;
    dp_d       = ACTIVO_BAJO ? ~punto_sel : punto_sel;
    digito_d   = idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      snap_valor_q <= '0;
      snap_punto_q <= '0;
      anodo_q      <= ANODO_OFF;
      segmento_q   <= SEG_OFF;
      dp_q         <= DP_OFF;
      digito_q     <= 3'd0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_valor_q <= snap_valor_d;
      snap_punto_q <= snap_punto_d;
      anodo_q      <= anodo_d;
      segmento_q   <= segmento_d;
      dp_q         <= dp_d;
      digito_q     <= digito_d;
    end
  end

  assign anodo         = anodo_q;
  assign segmento      = segmento_q;
  assign dp            = dp_q;
  assign digito_actual = digito_q;

endmodule

// File: tb/tb_controlador_displays_mux.sv
// Bench for controlador_displays_mux: an active-low and an active-high instance share stimulus;
// a cycle model queues the expected outputs which are popped one cycle later.
module tb_controlador_displays_mux;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BLK = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] valor = 16'h0;
  logic [3:0]  punto = 4'h0;
  logic        blank_ceros = 1'b0;
  logic        habilitar = 1'b0;

  logic [3:0]  anodo_l, anodo_h;
  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h;
  logic [2:0]  dig_l, dig_h;

  always #5 clk = ~clk;

  controlador_displays_mux #(.N_DIGITOS(N), .CLK_DIV(DIV), .BLANK_CYC(BLK), .ACTIVO_BAJO(1'b1)) dut_l (
    .clk(clk), .reset(reset), .valor(valor), .punto(punto), .blank_ceros(blank_ceros),
    .habilitar(habilitar), .anodo(anodo_l), .segmento(seg_l), .dp(dp_l), .digito_actual(dig_l));

  controlador_displays_mux #(.N_DIGITOS(N), .CLK_DIV(DIV), .BLANK_CYC(BLK), .ACTIVO_BAJO(1'b0)) dut_h (
    .clk(clk), .reset(reset), .valor(valor), .punto(punto), .blank_ceros(blank_ceros),
    .habilitar(habilitar), .anodo(anodo_h), .segmento(seg_h), .dp(dp_h), .digito_actual(dig_h));

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] dig;
    logic       care;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  string       phase = "reset";
  int          m_presc = 0;
  int          m_idx = 0;
  logic [15:0] m_sv = 16'h0;
  logic [3:0]  m_sp = 4'h0;

  function automatic logic [6:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %b expected %b", phase, tag, got, want);
    end
  endtask

  // One clock: queue the expectation for the inputs now applied, advance the model, then compare.
  task automatic cyc();
    exp_t        e;
    logic [15:0] v;
    logic [3:0]  p;
    logic [3:0]  nib;
    logic        cap, blanked, lit;
    if (reset) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, dig: 3'd0, care: 1'b1};
      m_presc = 0; m_idx = 0; m_sv = 16'h0; m_sp = 4'h0;
    end else begin
      cap     = (m_presc == 0) && (m_idx == 0);
      v       = cap ? valor : m_sv;
      p       = cap ? punto : m_sp;
      nib     = v[m_idx*4 +: 4];
      blanked = blank_ceros && (m_idx != 0) && ((v >> (4*m_idx)) == 16'h0);
      lit     = habilitar && (m_presc >= BLK);
      e.an    = lit ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg   = blanked ? 7'h7F : hex_code(nib);
      e.dp    = ~p[m_idx];
      e.dig   = 3'(m_idx);
      e.care  = lit;
      m_sv = v; m_sp = p;
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_idx   = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_presc++;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("anodo_l", {4'b0, anodo_l}, {4'b0, e.an});
    check("anodo_h", {4'b0, anodo_h}, {4'b0, ~e.an});
    check("digito_l", {5'b0, dig_l}, {5'b0, e.dig});
    check("digito_h", {5'b0, dig_h}, {5'b0, e.dig});
    if (e.care) begin
      check("seg_l", {1'b0, seg_l}, {1'b0, e.seg});
      check("seg_h", {1'b0, seg_h}, {1'b0, ~e.seg});
      check("dp_l", {7'b0, dp_l}, {7'b0, e.dp});
      check("dp_h", {7'b0, dp_h}, {7'b0, ~e.dp});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Bounded advance until the model's next cycle sits at the requested prescaler/index.
  task automatic align(input int idx, input int presc);
    int budget = 4 * DIV * N;
    while (!(m_idx == idx && m_presc == presc) && budget > 0) begin
      cyc();
      budget--;
    end
    vectors++;
    assert (m_idx == idx && m_presc == presc) else begin
      miscompares++;
      $error("FAIL %s/align: observed idx %0d expected %0d", phase, m_idx, idx);
    end
  endtask

  initial begin
    phase = "reset";
    reset = 1'b1;
    run(2);

    phase = "scan";
    reset = 1'b0; valor = 16'h1234; habilitar = 1'b1;
    run(2 * DIV * N);

    phase = "hex";
    align(0, 0);
    for (int h = 0; h < 16; h++) begin
      valor = {12'h000, 4'(h)};
      run(DIV * N);
    end

    phase = "lz";
    blank_ceros = 1'b1; valor = 16'h0050;
    run(2 * DIV * N);
    valor = 16'h0000;
    run(2 * DIV * N);
    punto = 4'b1000;
    run(2 * DIV * N);

    phase = "snap";
    blank_ceros = 1'b0; punto = 4'b0000; valor = 16'h1234;
    run(DIV * N);
    align(2, 1);
    valor = 16'hABCD;
    run(2 * DIV * N);

    phase = "hab";
    habilitar = 1'b0;
    run(5);
    habilitar = 1'b1;
    run(DIV * N);

    phase = "rst_mid";
    align(1, 2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(DIV * N);

    phase = "pol";
    valor = 16'h0008; punto = 4'b0001;
    run(2 * DIV * N);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
